// File: rtl/camera_capture.sv
// camera_capture: packs OV7670 byte pairs into RGB444 pixels, tracks the
// position of each pixel in the frame, and optionally keeps only the
// even-column/even-row pixels (2:1 in each axis). Single PCLK domain.
module camera_capture #(
    parameter int IN_WIDTH  = 640,
    parameter int IN_HEIGHT = 480,
    parameter int DECIMATE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic        ready_out,
    output logic [11:0] data_out,
    output logic [9:0]  out_x,
    output logic [8:0]  out_y,
    output logic        frame_active,
    output logic        frame_done,
    output logic        line_err
);

    typedef enum logic [1:0] {
        WAIT_SYNC  = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    localparam logic [9:0] WIDTH_L  = 10'(IN_WIDTH);
    localparam logic [8:0] HEIGHT_L = 9'(IN_HEIGHT);

    // Position counters stop at all-ones instead of wrapping, so an overlong
    // line or frame can never alias back into the visible area.
    function automatic logic [9:0] inc_sat_x(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [8:0] inc_sat_y(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    // ---- stage p0: pin registers and one-cycle-delayed copies for edge detect
    logic       vsync_p0_d, vsync_p0_q, href_p0_d, href_p0_q;
    logic [7:0] d_p0_d, d_p0_q;
    logic       vsync_p1_d, vsync_p1_q, href_p1_d, href_p1_q;

    // Capture the camera pins and remember the previous sampled levels.
    always_comb begin
        vsync_p0_d = vsync;
        href_p0_d  = href;
        d_p0_d     = d;
        vsync_p1_d = vsync_p0_q;
        href_p1_d  = href_p0_q;
    end

    // Register the pins; the sync levels are control and get reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_p0_q <= 1'b0;
            href_p0_q  <= 1'b0;
            vsync_p1_q <= 1'b0;
            href_p1_q  <= 1'b0;
        end else begin
            vsync_p0_q <= vsync_p0_d;
            href_p0_q  <= href_p0_d;
            vsync_p1_q <= vsync_p1_d;
            href_p1_q  <= href_p1_d;
        end
        d_p0_q <= d_p0_d;
    end

    logic vs_rise, vs_fall, hr_rise, hr_fall;
    assign vs_rise = vsync_p0_q & ~vsync_p1_q;
    assign vs_fall = ~vsync_p0_q & vsync_p1_q;
    assign hr_rise = href_p0_q & ~href_p1_q;
    assign hr_fall = ~href_p0_q & href_p1_q;

    // ---- stage p1: frame FSM, byte pairing, position tracking
    state_t state_q;
    logic   act_p1_q, done_p1_q;

    // Frame sequencing; a frame end always wins over a coincident line event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_SYNC;
            act_p1_q  <= 1'b0;
            done_p1_q <= 1'b0;
        end else begin
            done_p1_q <= 1'b0;
            case (state_q)
                WAIT_SYNC: begin
                    if (vsync_p0_q) state_q <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (vs_fall) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        state_q   <= WAIT_FRAME;
                        done_p1_q <= 1'b1;
                        act_p1_q  <= 1'b0;
                    end else if (hr_rise) begin
                        act_p1_q  <= 1'b1;
                    end
                end
                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

    logic        phase_d, phase_q;
    logic [3:0]  r_d, r_q;
    logic [9:0]  in_x_d, in_x_q;
    logic [8:0]  in_y_d, in_y_q;
    logic        line_err_d, line_err_q;
    logic        vld_p1_d, vld_p1_q;
    logic [11:0] pix_p1_d, pix_p1_q;
    logic [9:0]  x_p1_d, x_p1_q;
    logic [8:0]  y_p1_d, y_p1_q;
    logic        keep;

    // A pixel survives if it lies inside the frame and, when decimating,
    // sits on an even column of an even row.
    assign keep = (in_x_q < WIDTH_L) && (in_y_q < HEIGHT_L) &&
                  ((DECIMATE == 0) || (!in_x_q[0] && !in_y_q[0]));

    // Pair bytes into pixels, advance counters, and check line lengths.
    always_comb begin
        phase_d    = phase_q;
        r_d        = r_q;
        in_x_d     = in_x_q;
        in_y_d     = in_y_q;
        line_err_d = line_err_q;
        vld_p1_d   = 1'b0;
        pix_p1_d   = pix_p1_q;
        x_p1_d     = x_p1_q;
        y_p1_d     = y_p1_q;
        if (state_q == WAIT_FRAME && vs_fall) begin
            in_x_d  = 10'd0;
            in_y_d  = 9'd0;
            phase_d = 1'b0;
        end else if (state_q == ACTIVE && !vs_rise) begin
            if (href_p0_q) begin
                if (!phase_q) begin
                    r_d     = d_p0_q[3:0];
                    phase_d = 1'b1;
                end else begin
                    phase_d  = 1'b0;
                    pix_p1_d = {r_q, d_p0_q};
                    vld_p1_d = keep;
                    x_p1_d   = (DECIMATE != 0) ? {1'b0, in_x_q[9:1]} : in_x_q;
                    y_p1_d   = (DECIMATE != 0) ? {1'b0, in_y_q[8:1]} : in_y_q;
                    in_x_d   = inc_sat_x(in_x_q);
                end
            end else if (hr_fall) begin
                // Exactly IN_WIDTH whole pixels and no dangling byte.
                if (!(in_x_q == WIDTH_L && !phase_q)) line_err_d = 1'b1;
                phase_d = 1'b0;
                in_x_d  = 10'd0;
                in_y_d  = inc_sat_y(in_y_q);
            end
        end
    end

    // Register the assembled pixel and the tracking state.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= 1'b0;
            in_x_q     <= 10'd0;
            in_y_q     <= 9'd0;
            line_err_q <= 1'b0;
            vld_p1_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            in_x_q     <= in_x_d;
            in_y_q     <= in_y_d;
            line_err_q <= line_err_d;
            vld_p1_q   <= vld_p1_d;
        end
        r_q      <= r_d;
        pix_p1_q <= pix_p1_d;
        x_p1_q   <= x_p1_d;
        y_p1_q   <= y_p1_d;
    end

    // ---- stage p2: output registers; pixel fields hold between strobes
    logic        ready_out_d, ready_out_q;
    logic [11:0] data_out_d, data_out_q;
    logic [9:0]  out_x_d, out_x_q;
    logic [8:0]  out_y_d, out_y_q;
    logic        frame_active_d, frame_active_q;
    logic        frame_done_d, frame_done_q;

    // Load a new pixel only on a strobe; frame flags follow the FSM by one cycle.
    always_comb begin
        ready_out_d    = vld_p1_q;
        data_out_d     = vld_p1_q ? pix_p1_q : data_out_q;
        out_x_d        = vld_p1_q ? x_p1_q   : out_x_q;
        out_y_d        = vld_p1_q ? y_p1_q   : out_y_q;
        frame_active_d = act_p1_q;
        frame_done_d   = done_p1_q;
    end

    // Output flops, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_out_q    <= 1'b0;
            data_out_q     <= 12'd0;
            out_x_q        <= 10'd0;
            out_y_q        <= 9'd0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            ready_out_q    <= ready_out_d;
            data_out_q     <= data_out_d;
            out_x_q        <= out_x_d;
            out_y_q        <= out_y_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign ready_out    = ready_out_q;
    assign data_out     = data_out_q;
    assign out_x        = out_x_q;
    assign out_y        = out_y_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;
    assign line_err     = line_err_q;

endmodule
